// File: rtl/dht_uart_frame_seq.sv
// DHT11 sample -> "H=hh T=tt\r\n" text frame, paced on uart_tx busy handshake.
// Optional CHECKSUM_REPORT_EN: bad-checksum samples send "ERR\r\n" instead of being dropped.
module dht_uart_frame_seq #(
    parameter int START_TIMEOUT = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] hum_int,
    input  logic [7:0] temp_int,
    input  logic       checksum_ok,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       frame_busy,
    output logic       overrun
);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_CONV, S_SEND, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [6:0]    hrem_q, hrem_d, trem_q, trem_d;
    logic [3:0]    htens_q, htens_d, ttens_q, ttens_d;
    logic          err_q, err_d;
    logic          pv_q, pv_d, pc_q, pc_d, ovr_q, ovr_d;
    logic [7:0]    ph_q, ph_d, pt_q, pt_d;
    logic [7:0]    frame_byte;
    logic [3:0]    last_idx;

    assign last_idx = err_q ? 4'd4 : 4'd10;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            hrem_q  <= '0;
            trem_q  <= '0;
            htens_q <= '0;
            ttens_q <= '0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
            pc_q    <= 1'b0;
            ph_q    <= '0;
            pt_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            hrem_q  <= hrem_d;
            trem_q  <= trem_d;
            htens_q <= htens_d;
            ttens_q <= ttens_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
            pc_q    <= pc_d;
            ph_q    <= ph_d;
            pt_q    <= pt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        hrem_d  = hrem_q;
        trem_d  = trem_q;
        htens_d = htens_q;
        ttens_d = ttens_q;
        err_d   = err_q;
        pv_d    = pv_q;
        pc_d    = pc_q;
        ph_d    = ph_q;
        pt_d    = pt_q;
        ovr_d   = ovr_q;
        // Every arrival goes through the slot; CAPTURE drains it.
        if (state_q == S_CAPTURE) pv_d = 1'b0;
        if (sample_valid) begin
            if (pv_q && state_q != S_CAPTURE) ovr_d = 1'b1;
            pv_d = 1'b1;
            ph_d = hum_int;
            pt_d = temp_int;
            pc_d = checksum_ok;
        end
        unique case (state_q)
            S_IDLE: begin
                if (sample_valid || pv_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hrem_d  = (ph_q > 8'd99) ? 7'd99 : ph_q[6:0];
                trem_d  = (pt_q > 8'd99) ? 7'd99 : pt_q[6:0];
                htens_d = '0;
                ttens_d = '0;
                idx_d   = '0;
                err_d   = !pc_q;
`ifdef CHECKSUM_REPORT_EN
                state_d = pc_q ? S_CONV : S_SEND;
`else
                state_d = pc_q ? S_CONV : S_IDLE;
`endif
            end
            S_CONV: begin
                if (hrem_q >= 7'd10) begin
                    hrem_d  = hrem_q - 7'd10;
                    htens_d = htens_q + 4'd1;
                end else if (trem_q >= 7'd10) begin
                    trem_d  = trem_q - 7'd10;
                    ttens_d = ttens_q + 4'd1;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                tmo_d = TW'(1);
                if (!tx_busy) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) state_d = S_WAIT_LO;
                else if (tmo_q == TW'(START_TIMEOUT - 1)) state_d = S_SEND;
                else tmo_d = tmo_q + 1'b1;
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        if (err_q) begin
            case (idx_q)
                4'd0:       frame_byte = 8'h45;
                4'd1, 4'd2: frame_byte = 8'h52;
                4'd3:       frame_byte = 8'h0D;
                4'd4:       frame_byte = 8'h0A;
                default:    frame_byte = 8'h00;
            endcase
        end else begin
            case (idx_q)
                4'd0:    frame_byte = 8'h48;
                4'd1:    frame_byte = 8'h3D;
                4'd2:    frame_byte = 8'h30 + {4'h0, htens_q};
                4'd3:    frame_byte = 8'h30 + {1'b0, hrem_q};
                4'd4:    frame_byte = 8'h20;
                4'd5:    frame_byte = 8'h54;
                4'd6:    frame_byte = 8'h3D;
                4'd7:    frame_byte = 8'h30 + {4'h0, ttens_q};
                4'd8:    frame_byte = 8'h30 + {1'b0, trem_q};
                4'd9:    frame_byte = 8'h0D;
                4'd10:   frame_byte = 8'h0A;
                default: frame_byte = 8'h00;
            endcase
        end
        tx_start   = (state_q == S_SEND) && !tx_busy && !rst;
        tx_data    = (state_q == S_SEND || state_q == S_WAIT_HI ||
                      state_q == S_WAIT_LO) ? frame_byte : 8'h00;
        frame_busy = (state_q != S_IDLE);
        overrun    = ovr_q;
    end
endmodule
